// File: rtl/dr_pkg.sv
// Shared types and constants for the dual-rail four-phase receiver.
// A rail pair encodes one bit: 01 = false, 10 = true, 00 = NULL (spacer), 11 = illegal.
package dr_pkg;

    localparam int          RAIL_NUM = 2;
    localparam int          RAIL_T   = 1;
    localparam int          RAIL_F   = 0;
    localparam logic [1:0]  DR_NULL  = 2'b00;

    typedef logic [RAIL_NUM-1:0] dr_bit_t;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    // Both rails high cannot come from a well-behaved sender.
    function automatic logic pair_illegal(input dr_bit_t p);
        return (p[RAIL_T] == 1'b1) && (p[RAIL_F] == 1'b1);
    endfunction

endpackage

// File: rtl/dr_fp_rx_sync_sync_ff.sv
// N-flop synchroniser bringing one asynchronous level into the clk domain.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sh_r;

    // Shift chain; clears so that a level reappearing after reset is seen as a fresh rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r <= '0;
        end else begin
            sh_r <= {sh_r[N-2:0], d};
        end
    end

    assign q = sh_r[N-1];

endmodule

// File: rtl/dr_fp_rx_sync.sv
// Clocked sink for a four-phase dual-rail channel: detects completion and NULL, captures the word,
// returns the four-phase ack and presents the binary word on a valid/ready interface.
module dr_fp_rx_sync
    import dr_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SYNC_N  = 2,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  dr_bit_t [WIDTH-1:0]  in,
    output logic                 ack_o,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 err_o,
    output logic [COUNT_W-1:0]   words_o
);

    logic             det_valid_s;
    logic             det_null_s;
    logic             any_illegal_s;
    logic [WIDTH-1:0] bin_s;
    logic             all_valid_s;
    logic             all_null_s;

    rx_state_t        state_r;
    rx_state_t        state_next_s;
    logic             ack_r;
    logic             capture_s;
    logic             pop_s;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             err_r;
    logic [COUNT_W-1:0] words_r;

    // Completion / NULL detect on the raw asynchronous word.
    always_comb begin
        det_valid_s   = 1'b1;
        det_null_s    = 1'b1;
        any_illegal_s = 1'b0;
        bin_s         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i] == DR_NULL) begin
                det_valid_s = 1'b0;
            end else begin
                det_null_s = 1'b0;
            end
            any_illegal_s = any_illegal_s | pair_illegal(in[i]);
            bin_s[i]      = in[i][RAIL_T];
        end
    end

    sync_ff #(.N(SYNC_N)) u_sync_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (det_valid_s),
        .q     (all_valid_s)
    );

    sync_ff #(.N(SYNC_N)) u_sync_null (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (det_null_s),
        .q     (all_null_s)
    );

    // State register; ack is registered from the next state so it leaves the block glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ack_r   <= (state_next_s == RX_ACK);
        end
    end

    // Next-state logic; in stays untouched until the synchronised completion says it is stable.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (capture_s) begin
                    state_next_s = RX_ACK;
                end else begin
                    state_next_s = RX_IDLE;
                end
            end
            RX_ACK: begin
                if (all_null_s) begin
                    state_next_s = RX_IDLE;
                end else begin
                    state_next_s = RX_ACK;
                end
            end
            default: state_next_s = RX_IDLE;
        endcase
    end

    // FSM outputs: capture only with room downstream, otherwise the withheld ack stalls the sender.
    always_comb begin
        pop_s     = dout_valid_r & dout_ready;
        capture_s = 1'b0;
        case (state_r)
            RX_IDLE: capture_s = all_valid_s & (~dout_valid_r | dout_ready);
            RX_ACK:  capture_s = 1'b0;
            default: capture_s = 1'b0;
        endcase
    end

    // Output word register; a capture on the pop edge refills it so valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else if (capture_s && !any_illegal_s) begin
            dout_r       <= bin_s;
            dout_valid_r <= 1'b1;
        end else if (pop_s) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    // Sticky error for illegal pairs (the word is dropped but still acked) and delivered-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r   <= 1'b0;
            words_r <= '0;
        end else begin
            if (capture_s && any_illegal_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (pop_s) begin
                words_r <= words_r + COUNT_W'(1);
            end else begin
                words_r <= words_r;
            end
        end
    end

    assign ack_o      = ack_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign err_o      = err_r;
    assign words_o    = words_r;

endmodule

// File: tb/tb_dr_fp_rx_sync.sv
// Self-checking bench for dr_fp_rx_sync: behavioural four-phase sender plus an output scoreboard.
module tb_dr_fp_rx_sync;
    import dr_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SYNC_N  = 2;
    localparam int COUNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    dr_bit_t [WIDTH-1:0]  din;
    logic                 ack_o;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic                 dout_ready = 1'b0;
    logic                 err_o;
    logic [COUNT_W-1:0]   words_o;

    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   exp_words = 0;
    logic [WIDTH-1:0]     sb[$];
    logic                 fib_done;

    dr_fp_rx_sync #(.WIDTH(WIDTH), .SYNC_N(SYNC_N), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (din),
        .ack_o      (ack_o),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && dout_valid && dout_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: dout=%h delivered, none expected", dout);
                end else begin
                    e = sb.pop_front();
                    if (dout !== e) begin
                        n_err++;
                        $display("FAIL sb_dout: got %h expected %h", dout, e);
                    end
                end
                exp_words++;
            end
        end
    endtask

    function automatic dr_bit_t [WIDTH-1:0] encode(input logic [WIDTH-1:0] v);
        dr_bit_t [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic drive_word(input logic [WIDTH-1:0] v, input int bad_bit);
        din = encode(v);
        if (bad_bit >= 0) din[bad_bit] = 2'b11;
        else sb.push_back(v);
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (ack_o === lvl) break;
        end
        n_cmp++;
        if (k == 100) begin
            n_err++;
            $display("FAIL %s: ack_o stuck at %b, required %b", name, ack_o, lvl);
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] v, input int bad_bit);
        drive_word(v, bad_bit);
        wait_ack(1'b1, "ack_rise");
        din = '0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic check_drained(input string name);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0 || words_o !== COUNT_W'(exp_words)) begin
            n_err++;
            $display("FAIL %s: pending=%0d words_o=%0d, required pending=0 words_o=%0d",
                     name, sb.size(), words_o, exp_words);
        end
    endtask

    task automatic test_reset();
        din = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack_o, dout, dout_valid, err_o, words_o} !== '0) begin
            n_err++;
            $display("FAIL reset_state: ack=%b dout=%h valid=%b err=%b words=%0d, required all 0",
                     ack_o, dout, dout_valid, err_o, words_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int cnt;
        dout_ready = 1'b1;
        drive_word(32'h0000_0005, -1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; cnt++;
            if (ack_o) break;
        end
        n_cmp++;
        if (cnt != SYNC_N + 1) begin
            n_err++;
            $display("FAIL ack_rise_latency: %0d edges, required %0d", cnt, SYNC_N + 1);
        end
        din = '0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; cnt++;
            if (!ack_o) break;
        end
        n_cmp++;
        if (cnt != SYNC_N + 1) begin
            n_err++;
            $display("FAIL ack_fall_latency: %0d edges, required %0d", cnt, SYNC_N + 1);
        end
        check_drained("single_drain");
        n_cmp++;
        if (words_o !== 16'd1) begin
            n_err++;
            $display("FAIL single_words: words_o=%0d, required 1", words_o);
        end
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        send_word(32'h0000_0007, -1);
        drive_word(32'h0000_0009, -1);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (ack_o !== 1'b0 || dout !== 32'h7 || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: ack=%b dout=%h valid=%b, required ack=0 dout=7 valid=1",
                     ack_o, dout, dout_valid);
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (dout !== 32'h9 || dout_valid !== 1'b1 || ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pop_capture: dout=%h valid=%b ack=%b, required dout=9 valid=1 ack=1",
                     dout, dout_valid, ack_o);
        end
        din = '0;
        wait_ack(1'b0, "bp_ack_fall");
        check_drained("bp_drain");
        n_cmp++;
        if (words_o !== 16'd3) begin
            n_err++;
            $display("FAIL bp_words: words_o=%0d, required 3", words_o);
        end
    endtask

    task automatic test_illegal();
        dout_ready = 1'b1;
        send_word(32'h0000_00F0, 3);
        n_cmp++;
        if (err_o !== 1'b1 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_drop: err=%b valid=%b, required err=1 valid=0", err_o, dout_valid);
        end
        send_word(32'h1234_5678, -1);
        check_drained("illegal_next");
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_sticky: err=%b, required 1", err_o);
        end
    endtask

    task automatic test_partial();
        logic [WIDTH-1:0] v;
        dr_bit_t [WIDTH-1:0] full;
        v = 32'h3C3C_9617;
        full = encode(v);
        dout_ready = 1'b1;
        din = '0;
        sb.push_back(v);
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < WIDTH; i++) if ((i % 10) == c) din[i] = full[i];
            @(posedge clk); #1;
            if (c < 9) begin
                n_cmp++;
                if (ack_o !== 1'b0 || dout_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL partial_hold[%0d]: ack=%b valid=%b, required 0 0", c, ack_o, dout_valid);
                end
            end
        end
        wait_ack(1'b1, "partial_ack_rise");
        din = '0;
        wait_ack(1'b0, "partial_ack_fall");
        check_drained("partial_drain");
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] v;
        v = 32'hA5A5_0F0F;
        dout_ready = 1'b0;
        drive_word(v, -1);
        wait_ack(1'b1, "rst_mid_ack");
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ack_o !== 1'b0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_drop: ack=%b valid=%b, required 0 0", ack_o, dout_valid);
        end
        sb.delete();
        exp_words = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.push_back(v);
        wait_ack(1'b1, "rst_recapture");
        n_cmp++;
        if (dout !== v || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_recapture_word: dout=%h valid=%b, required %h 1", dout, dout_valid, v);
        end
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_single_capture: valid=%b, required 0", dout_valid);
        end
        din = '0;
        wait_ack(1'b0, "rst_ack_fall");
        check_drained("rst_drain");
        n_cmp++;
        if (words_o !== 16'd1) begin
            n_err++;
            $display("FAIL rst_words: words_o=%0d, required 1", words_o);
        end
    endtask

    task automatic test_fib();
        logic [WIDTH-1:0] a, b, t;
        a = '0;
        b = 32'd1;
        fib_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    send_word(a, -1);
                    t = a + b;
                    a = b;
                    b = t;
                end
                fib_done = 1'b1;
            end
            begin
                while (!fib_done) begin
                    @(posedge clk); #1;
                    dout_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_ready = 1'b1;
        check_drained("fib_drain");
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL fib_err: err=%b, required 0", err_o);
        end
    endtask

    initial begin
        din = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_illegal();
        // Reset clears the sticky error before the remaining tests.
        test_reset();
        exp_words = 0;
        test_partial();
        test_reset_mid();
        test_fib();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
